// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for a 5-stage RISC-V pipeline.
// Ports: clk_i/rst_i; ID fields (id_rs1_i, id_rs2_i, id_use_rs1_i, id_use_rs2_i,
//   id_rd_i, id_reg_write_i, id_mem_read_i); flush_i, hold_i;
//   forwarding_rs1_o/forwarding_rs2_o (EXE operand select), stall_o, lu_stall_cnt_o.
module fwd_hazard_unit (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [4:0]  id_rs1_i,
    input  logic [4:0]  id_rs2_i,
    input  logic        id_use_rs1_i,
    input  logic        id_use_rs2_i,
    input  logic [4:0]  id_rd_i,
    input  logic        id_reg_write_i,
    input  logic        id_mem_read_i,
    input  logic        flush_i,
    input  logic        hold_i,
    output logic [1:0]  forwarding_rs1_o,
    output logic [1:0]  forwarding_rs2_o,
    output logic        stall_o,
    output logic [15:0] lu_stall_cnt_o
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    // EX shadow entry
    logic [4:0]  ex_rd_q,   ex_rd_d;
    logic        ex_we_q,   ex_we_d;
    logic        ex_mr_q,   ex_mr_d;
    logic [4:0]  ex_rs1_q,  ex_rs1_d;
    logic [4:0]  ex_rs2_q,  ex_rs2_d;
    logic        ex_use1_q, ex_use1_d;
    logic        ex_use2_q, ex_use2_d;
    // MEM shadow entry
    logic [4:0]  mem_rd_q,  mem_rd_d;
    logic        mem_we_q,  mem_we_d;
    logic        mem_mr_q,  mem_mr_d;
    // WB shadow entry
    logic [4:0]  wb_rd_q,   wb_rd_d;
    logic        wb_we_q,   wb_we_d;
    // Registered outputs
    logic [1:0]  fwd1_q,    fwd1_d;
    logic [1:0]  fwd2_q,    fwd2_d;
    logic [15:0] cnt_q,     cnt_d;

    logic stall;
    logic bubble;

    // A producer matches a consumer only if it writes a non-x0 register
    // that the consumer actually reads.
    function automatic logic hit(input logic we, input logic [4:0] rd,
                                 input logic [4:0] rs, input logic use_rs);
        return we && (rd != 5'd0) && (rd == rs) && use_rs;
    endfunction

    function automatic logic [1:0] sel(input logic [4:0] rs, input logic use_rs,
                                       input logic exw, input logic [4:0] exrd,
                                       input logic mw, input logic [4:0] mrd);
        if (hit(exw, exrd, rs, use_rs))
            return FWD_MEM;
        else if (hit(mw, mrd, rs, use_rs))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    // Load in EX feeding the ID instruction; a flush squashes the consumer
    // so there is nothing to wait for.
    always_comb begin
        stall = ex_mr_q &&
                (hit(ex_we_q, ex_rd_q, id_rs1_i, id_use_rs1_i) ||
                 hit(ex_we_q, ex_rd_q, id_rs2_i, id_use_rs2_i)) &&
                !flush_i;
        bubble = stall || flush_i;
    end

    always_comb begin
        ex_rd_d   = ex_rd_q;
        ex_we_d   = ex_we_q;
        ex_mr_d   = ex_mr_q;
        ex_rs1_d  = ex_rs1_q;
        ex_rs2_d  = ex_rs2_q;
        ex_use1_d = ex_use1_q;
        ex_use2_d = ex_use2_q;
        mem_rd_d  = mem_rd_q;
        mem_we_d  = mem_we_q;
        mem_mr_d  = mem_mr_q;
        wb_rd_d   = wb_rd_q;
        wb_we_d   = wb_we_q;
        fwd1_d    = fwd1_q;
        fwd2_d    = fwd2_q;
        cnt_d     = cnt_q;
        if (!hold_i) begin
            wb_rd_d  = mem_rd_q;
            wb_we_d  = mem_we_q;
            mem_rd_d = ex_rd_q;
            mem_we_d = ex_we_q;
            mem_mr_d = ex_mr_q;
            if (bubble) begin
                ex_rd_d   = 5'd0;
                ex_we_d   = 1'b0;
                ex_mr_d   = 1'b0;
                ex_rs1_d  = 5'd0;
                ex_rs2_d  = 5'd0;
                ex_use1_d = 1'b0;
                ex_use2_d = 1'b0;
                fwd1_d    = FWD_RF;
                fwd2_d    = FWD_RF;
            end else begin
                ex_rd_d   = id_rd_i;
                ex_we_d   = id_reg_write_i;
                ex_mr_d   = id_mem_read_i;
                ex_rs1_d  = id_rs1_i;
                ex_rs2_d  = id_rs2_i;
                ex_use1_d = id_use_rs1_i;
                ex_use2_d = id_use_rs2_i;
                fwd1_d = sel(id_rs1_i, id_use_rs1_i,
                             ex_we_q, ex_rd_q, mem_we_q, mem_rd_q);
                fwd2_d = sel(id_rs2_i, id_use_rs2_i,
                             ex_we_q, ex_rd_q, mem_we_q, mem_rd_q);
            end
            if (stall && (cnt_q != 16'hFFFF))
                cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ex_rd_q   <= 5'd0;
            ex_we_q   <= 1'b0;
            ex_mr_q   <= 1'b0;
            ex_rs1_q  <= 5'd0;
            ex_rs2_q  <= 5'd0;
            ex_use1_q <= 1'b0;
            ex_use2_q <= 1'b0;
            mem_rd_q  <= 5'd0;
            mem_we_q  <= 1'b0;
            mem_mr_q  <= 1'b0;
            wb_rd_q   <= 5'd0;
            wb_we_q   <= 1'b0;
            fwd1_q    <= FWD_RF;
            fwd2_q    <= FWD_RF;
            cnt_q     <= 16'd0;
        end else begin
            ex_rd_q   <= ex_rd_d;
            ex_we_q   <= ex_we_d;
            ex_mr_q   <= ex_mr_d;
            ex_rs1_q  <= ex_rs1_d;
            ex_rs2_q  <= ex_rs2_d;
            ex_use1_q <= ex_use1_d;
            ex_use2_q <= ex_use2_d;
            mem_rd_q  <= mem_rd_d;
            mem_we_q  <= mem_we_d;
            mem_mr_q  <= mem_mr_d;
            wb_rd_q   <= wb_rd_d;
            wb_we_q   <= wb_we_d;
            fwd1_q    <= fwd1_d;
            fwd2_q    <= fwd2_d;
            cnt_q     <= cnt_d;
        end
    end

    assign forwarding_rs1_o = fwd1_q;
    assign forwarding_rs2_o = fwd2_q;
    assign stall_o          = stall;
    assign lu_stall_cnt_o   = cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit.
// Expected codes/counter are queued per driven cycle and checked after the edge.
module tb_fwd_hazard_unit;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [4:0]  id_rs1_i = '0;
    logic [4:0]  id_rs2_i = '0;
    logic        id_use_rs1_i = 1'b0;
    logic        id_use_rs2_i = 1'b0;
    logic [4:0]  id_rd_i = '0;
    logic        id_reg_write_i = 1'b0;
    logic        id_mem_read_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        hold_i = 1'b0;
    logic [1:0]  forwarding_rs1_o;
    logic [1:0]  forwarding_rs2_o;
    logic        stall_o;
    logic [15:0] lu_stall_cnt_o;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [1:0]  f1;
        logic [1:0]  f2;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    fwd_hazard_unit dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .id_rs1_i(id_rs1_i),
        .id_rs2_i(id_rs2_i),
        .id_use_rs1_i(id_use_rs1_i),
        .id_use_rs2_i(id_use_rs2_i),
        .id_rd_i(id_rd_i),
        .id_reg_write_i(id_reg_write_i),
        .id_mem_read_i(id_mem_read_i),
        .flush_i(flush_i),
        .hold_i(hold_i),
        .forwarding_rs1_o(forwarding_rs1_o),
        .forwarding_rs2_o(forwarding_rs2_o),
        .stall_o(stall_o),
        .lu_stall_cnt_o(lu_stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one ID slot, check combinational stall, queue the expected
    // post-edge state, then pop and compare after the edge.
    task automatic step(input string tag,
                        input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic we, input logic mr,
                        input logic fl, input logic hd, input logic es,
                        input logic [1:0] e1, input logic [1:0] e2,
                        input logic [15:0] ec);
        exp_t e;
        @(negedge clk_i);
        id_rs1_i = rs1;
        id_use_rs1_i = u1;
        id_rs2_i = rs2;
        id_use_rs2_i = u2;
        id_rd_i = rd;
        id_reg_write_i = we;
        id_mem_read_i = mr;
        flush_i = fl;
        hold_i = hd;
        #1;
        chk({tag, ".stall"}, 32'(stall_o), 32'(es));
        exp_q.push_back('{f1: e1, f2: e2, cnt: ec});
        @(posedge clk_i);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, ".queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".f1"}, 32'(forwarding_rs1_o), 32'(e.f1));
            chk({tag, ".f2"}, 32'(forwarding_rs2_o), 32'(e.f2));
            chk({tag, ".cnt"}, 32'(lu_stall_cnt_o), 32'(e.cnt));
        end
    endtask

    initial begin
        #12;
        chk("rst.f1", 32'(forwarding_rs1_o), 32'd0);
        chk("rst.f2", 32'(forwarding_rs2_o), 32'd0);
        chk("rst.stall", 32'(stall_o), 32'd0);
        chk("rst.cnt", 32'(lu_stall_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;

        //     tag   rs1 u  rs2 u  rd we mr fl hd  st f1 f2 cnt
        // EX/MEM forwarding
        step("A", 1, 1, 2, 1,  5, 1, 0, 0, 0, 0, 0, 0, 0);
        step("B", 5, 1, 3, 1, 10, 1, 0, 0, 0, 0, 1, 0, 0);
        step("C", 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // MEM/WB forwarding
        step("D", 0, 0, 0, 0,  6, 1, 0, 0, 0, 0, 0, 0, 0);
        step("E", 1, 1, 2, 1,  9, 1, 0, 0, 0, 0, 0, 0, 0);
        step("F", 6, 1, 3, 1,  0, 0, 0, 0, 0, 0, 2, 0, 0);
        // both match: EX/MEM wins
        step("G", 0, 0, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0, 0);
        step("H", 5, 1, 0, 0,  5, 1, 0, 0, 0, 0, 1, 0, 0);
        step("I", 5, 1, 5, 1,  0, 0, 0, 0, 0, 0, 1, 1, 0);
        // match without use flag never forwards
        step("J", 5, 0, 5, 0,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // x0 producer (a load) never forwards or stalls
        step("K", 0, 0, 0, 0,  0, 1, 1, 0, 0, 0, 0, 0, 0);
        step("L", 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        step("M", 0, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs2: one stall, bubble, then MEM/WB code
        step("N", 1, 1, 0, 0,  7, 1, 1, 0, 0, 0, 0, 0, 0);
        step("O1", 2, 1, 7, 1,  0, 0, 0, 0, 0, 1, 0, 0, 1);
        step("O2", 2, 1, 7, 1,  0, 0, 0, 0, 0, 0, 0, 2, 1);
        // flush beats load-use
        step("P", 0, 0, 0, 0,  8, 1, 1, 0, 0, 0, 0, 0, 1);
        step("Q", 8, 1, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        step("R", 8, 1, 0, 0, 12, 1, 0, 0, 0, 0, 2, 0, 1);
        // hold freezes codes
        step("S", 12, 1, 0, 0, 11, 1, 0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 3; i++)
            step("Th", 0, 0, 11, 1, 0, 0, 0, 0, 1, 0, 1, 0, 1);
        step("T", 0, 0, 11, 1,  0, 0, 0, 0, 0, 0, 0, 1, 1);
        // hold during a load-use stall freezes the counter
        step("U", 0, 0, 0, 0, 13, 1, 1, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step("Vh", 13, 1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1);
        step("V1", 13, 1, 0, 0,  0, 0, 0, 0, 0, 1, 0, 0, 2);
        step("V2", 13, 1, 0, 0,  0, 0, 0, 0, 0, 0, 2, 0, 2);

        // asynchronous reset in the middle of a load-use stall
        step("W", 0, 0, 0, 0, 14, 1, 1, 0, 0, 0, 0, 0, 2);
        @(negedge clk_i);
        id_rs1_i = 5'd14;
        id_use_rs1_i = 1'b1;
        id_rs2_i = 5'd0;
        id_use_rs2_i = 1'b0;
        id_rd_i = 5'd0;
        id_reg_write_i = 1'b0;
        id_mem_read_i = 1'b0;
        #1;
        chk("X.stall", 32'(stall_o), 32'd1);
        #1;
        rst_i = 1'b1;
        #1;
        chk("Xr.stall", 32'(stall_o), 32'd0);
        chk("Xr.f1", 32'(forwarding_rs1_o), 32'd0);
        chk("Xr.f2", 32'(forwarding_rs2_o), 32'd0);
        chk("Xr.cnt", 32'(lu_stall_cnt_o), 32'd0);
        @(negedge clk_i);
        rst_i = 1'b0;
        // normal operation right after release
        step("Y", 14, 1, 0, 0,  5, 1, 0, 0, 0, 0, 0, 0, 0);
        step("Z", 5, 1, 0, 0,   0, 0, 0, 0, 0, 0, 1, 0, 0);

        chk("queue.empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
